// File: rtl/brg_pkg.sv
// brg_pkg: shared rate codes, FSM states and generator timing constants
// for the baud-rate generator select controller.
package brg_pkg;

    localparam logic [1:0] RATE_115200 = 2'b00;
    localparam logic [1:0] RATE_38400  = 2'b01;
    localparam logic [1:0] RATE_19200  = 2'b10;
    localparam logic [1:0] RATE_9600   = 2'b11;

    localparam int DIV1        = 34;
    localparam int HALF_115200 = DIV1;
    localparam int HALF_38400  = DIV1 * 3;
    localparam int HALF_19200  = DIV1 * 6;
    localparam int HALF_9600   = DIV1 * 12;

    localparam int CNT_W = 11;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WAIT_LOW,
        SWITCH,
        SETTLE,
        GRANT
    } state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    typedef struct packed {
        req_id_t    id;
        logic [1:0] sel;
    } tgt_t;

    // Generator half-period in system clocks for a given rate code.
    function automatic int half_cyc(input logic [1:0] rate);
        int h;
        unique case (rate)
            RATE_115200: h = HALF_115200;
            RATE_38400:  h = HALF_38400;
            RATE_19200:  h = HALF_19200;
            default:     h = HALF_9600;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/brg_rate_ctrl_sync.sv
// brg_edge_sync: N-stage synchroniser for the generator output with
// registered-previous rise/fall pulse detection.
module brg_edge_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [N-1:0] sync_q;
    logic         prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[N-2:0], din};
            prev_q <= sync_q[N-1];
        end
    end

    assign rise = sync_q[N-1] & ~prev_q;
    assign fall = ~sync_q[N-1] & prev_q;

endmodule

// File: rtl/brg_rate_ctrl.sv
// brg_rate_ctrl: round-robin arbiter for rate-change requests that
// sequences glitch-free baud generator switches.
module brg_rate_ctrl
    import brg_pkg::*;
#(
    parameter int RST_CYC     = 4,
    parameter int TMO_CYC     = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_a,
    input  logic [1:0] sel_a,
    input  logic       req_b,
    input  logic [1:0] sel_b,
    output logic       gnt_a,
    output logic       gnt_b,
    input  logic       brg_clkout,
    output logic [1:0] brg_sel,
    output logic       brg_reset,
    output logic       busy,
    output logic       tmo_err
);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    if (TMO_CYC <= HALF_9600 || TMO_CYC > (1 << CNT_W)) begin : g_bad_tmo
        $error("brg_rate_ctrl: TMO_CYC out of range");
    end

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    tgt_t             tgt, tgt_nx;
    req_id_t          rr_ptr, rr_nx, win;
    logic [1:0]       win_sel, sel_nx;
    logic             rst_nx, gnt_a_nx, gnt_b_nx, tmo_nx;
    logic             rise, fall;

    brg_edge_sync #(
        .N (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (brg_clkout),
        .rise  (rise),
        .fall  (fall)
    );

    // On a tie the requester served last time yields.
    always_comb begin
        win = REQ_A;
        unique case (1'b1)
            req_a && req_b:  win = (rr_ptr == REQ_A) ? REQ_B : REQ_A;
            !req_a && req_b: win = REQ_B;
            default:         win = REQ_A;
        endcase
        win_sel = (win == REQ_A) ? sel_a : sel_b;
    end

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt_inc;
        tgt_nx   = tgt;
        rr_nx    = rr_ptr;
        sel_nx   = brg_sel;
        rst_nx   = brg_reset;
        gnt_a_nx = 1'b0;
        gnt_b_nx = 1'b0;
        tmo_nx   = tmo_err;
        unique case (state)
            INIT: begin
                if (cnt == RST_LAST) begin
                    state_nx = IDLE;
                    rst_nx   = 1'b0;
                    cnt_nx   = '0;
                end
            end
            IDLE: begin
                cnt_nx = '0;
                if (req_a || req_b) begin
                    tgt_nx   = '{id: win, sel: win_sel};
                    state_nx = (win_sel == brg_sel) ? GRANT : WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (fall || cnt == TMO_LAST) begin
                    state_nx = SWITCH;
                    sel_nx   = tgt.sel;
                    rst_nx   = 1'b1;
                    cnt_nx   = '0;
                    tmo_nx   = tmo_err | ~fall;
                end
            end
            SWITCH: begin
                if (cnt == RST_LAST) begin
                    state_nx = SETTLE;
                    rst_nx   = 1'b0;
                    cnt_nx   = '0;
                end
            end
            SETTLE: begin
                if (rise || cnt == TMO_LAST) begin
                    state_nx = GRANT;
                    cnt_nx   = '0;
                    tmo_nx   = tmo_err | ~rise;
                end
            end
            GRANT: begin
                gnt_a_nx = (tgt.id == REQ_A);
                gnt_b_nx = (tgt.id == REQ_B);
                rr_nx    = tgt.id;
                cnt_nx   = '0;
                state_nx = IDLE;
            end
            default: begin
                state_nx = INIT;
                rst_nx   = 1'b1;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= INIT;
            cnt       <= '0;
            tgt       <= '{id: REQ_A, sel: RATE_115200};
            rr_ptr    <= REQ_A;
            brg_sel   <= RATE_115200;
            brg_reset <= 1'b1;
            busy      <= 1'b1;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            tmo_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            tgt       <= tgt_nx;
            rr_ptr    <= rr_nx;
            brg_sel   <= sel_nx;
            brg_reset <= rst_nx;
            busy      <= (state != IDLE);
            gnt_a     <= gnt_a_nx;
            gnt_b     <= gnt_b_nx;
            tmo_err   <= tmo_nx;
        end
    end

endmodule

// File: tb/tb_brg_rate_ctrl.sv
// tb_brg_rate_ctrl: directed checks of brg_rate_ctrl against a
// behavioural baud generator model.
module tb_brg_rate_ctrl;
    import brg_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic [1:0] sel_a = 2'b00, sel_b = 2'b00;
    logic       gnt_a, gnt_b, brg_clkout, brg_reset, busy, tmo_err;
    logic [1:0] brg_sel;

    logic gen_clk = 1'b0;
    int   gen_cnt = 0;
    logic stuck = 1'b0;

    int n_cmp = 0, n_bad = 0;
    int g_a = 0, g_b = 0, ovl = 0;

    brg_rate_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req_a      (req_a),
        .sel_a      (sel_a),
        .req_b      (req_b),
        .sel_b      (sel_b),
        .gnt_a      (gnt_a),
        .gnt_b      (gnt_b),
        .brg_clkout (brg_clkout),
        .brg_sel    (brg_sel),
        .brg_reset  (brg_reset),
        .busy       (busy),
        .tmo_err    (tmo_err)
    );

    always #4 clk = ~clk;

    always @(posedge clk) begin
        if (brg_reset) begin
            gen_cnt <= 0;
            gen_clk <= 1'b0;
        end else if (gen_cnt >= half_cyc(brg_sel) - 1) begin
            gen_cnt <= 0;
            gen_clk <= ~gen_clk;
        end else begin
            gen_cnt <= gen_cnt + 1;
        end
    end

    assign brg_clkout = gen_clk & ~stuck;

    always @(negedge clk) begin
        if (gnt_a === 1'b1) g_a++;
        if (gnt_b === 1'b1) g_b++;
        if (gnt_a === 1'b1 && gnt_b === 1'b1) ovl++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rst_hi(input int lim);
        int n;
        n = 0;
        while (brg_reset !== 1'b1 && n < lim) begin
            cyc();
            n++;
        end
    endtask

    task automatic wait_gnt(input int lim);
        int n;
        n = 0;
        while (gnt_a !== 1'b1 && gnt_b !== 1'b1 && n < lim) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        int n, k, ta, tb, g0;
        logic prev_tmo, rmax, sel_at_a, first_b;
        logic [1:0] sa, sb;

        // reset release, no requests
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_brg_reset", brg_reset, 1);
        chk("rst_busy", busy, 1);
        chk("rst_brg_sel", brg_sel, 0);
        chk("rst_gnt", {gnt_a, gnt_b}, 0);
        chk("rst_tmo", tmo_err, 0);
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk($sformatf("init_rst_c%0d", i), brg_reset, (i <= 3));
            chk($sformatf("init_busy_c%0d", i), busy, (i <= 4));
        end
        chk("init_no_gnt", g_a + g_b, 0);
        chk("init_sel", brg_sel, 0);

        // fast path: same rate, no reset pulse
        req_b = 1'b1;
        sel_b = 2'b00;
        cyc();
        chk("fp_gnt_c1", gnt_b, 0);
        chk("fp_busy_c1", busy, 0);
        cyc();
        chk("fp_gnt_c2", gnt_b, 1);
        chk("fp_rst_c2", brg_reset, 0);
        chk("fp_busy_c2", busy, 1);
        req_b = 1'b0;
        cyc();
        chk("fp_gnt_c3", gnt_b, 0);
        chk("fp_rst_c3", brg_reset, 0);
        chk("fp_busy_c3", busy, 0);

        // full switch to 9600
        req_a = 1'b1;
        sel_a = 2'b11;
        wait_rst_hi(200);
        chk("sw_rst_seen", brg_reset, 1);
        chk("sw_sel", brg_sel, 3);
        chk("sw_after_fall", brg_clkout, 0);
        k = 1;
        for (int i = 0; i < 20 && brg_reset; i++) begin
            cyc();
            if (brg_reset) k++;
        end
        chk("sw_rst_len", k, 4);
        wait_gnt(1000);
        chk("sw_gnt_a", gnt_a, 1);
        chk("sw_gnt_b", gnt_b, 0);
        chk("sw_clk_running", brg_clkout, 1);
        chk("sw_busy_at_gnt", busy, 1);
        req_a = 1'b0;
        cyc();
        chk("sw_busy_after", busy, 0);
        chk("sw_gnt_single", gnt_a, 0);

        // stuck generator: timeouts in WAIT_LOW and SETTLE
        stuck = 1'b1;
        repeat (10) cyc();
        chk("tmo_pre", tmo_err, 0);
        req_a = 1'b1;
        sel_a = 2'b01;
        n = 0;
        prev_tmo = 1'b0;
        while (n < 1100) begin
            prev_tmo = tmo_err;
            cyc();
            n++;
            if (brg_reset) break;
        end
        chk("tmo_wl_cycles", n, 1025);
        chk("tmo_wl_before", prev_tmo, 0);
        chk("tmo_wl_flag", tmo_err, 1);
        chk("tmo_wl_sel", brg_sel, 1);
        n = 0;
        while (n < 1100 && gnt_a !== 1'b1) begin
            cyc();
            n++;
        end
        chk("tmo_st_cycles", n, 1029);
        chk("tmo_st_flag", tmo_err, 1);
        req_a = 1'b0;
        stuck = 1'b0;
        repeat (5) cyc();
        chk("tmo_sticky", tmo_err, 1);

        // both requests, different rates, rr_ptr=A
        g0 = g_a + g_b;
        req_a = 1'b1;
        sel_a = 2'b01;
        req_b = 1'b1;
        sel_b = 2'b10;
        sa = 2'b00;
        sb = 2'b00;
        sel_at_a = 1'b0;
        first_b = 1'b0;
        for (int i = 0; i < 3000 && (req_a || req_b); i++) begin
            cyc();
            if (gnt_b) begin
                sb = brg_sel;
                if (req_a) first_b = 1'b1;
                req_b = 1'b0;
            end
            if (gnt_a) begin
                sa = brg_sel;
                sel_at_a = 1'b1;
                req_a = 1'b0;
            end
        end
        cyc();
        chk("rr_b_first", first_b, 1);
        chk("rr_a_done", sel_at_a, 1);
        chk("rr_sel_b", sb, 2);
        chk("rr_sel_a", sa, 1);
        chk("rr_gnt_count", g_a + g_b - g0, 2);

        // both requests, equal rate: two fast-path grants
        req_a = 1'b1;
        sel_a = 2'b01;
        req_b = 1'b1;
        sel_b = 2'b01;
        ta = 0;
        tb = 0;
        rmax = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            if (brg_reset) rmax = 1'b1;
            if (gnt_a) begin
                ta = i;
                req_a = 1'b0;
            end
            if (gnt_b) begin
                tb = i;
                req_b = 1'b0;
            end
        end
        chk("eq_gnt_b_cyc", tb, 2);
        chk("eq_gnt_a_cyc", ta, 4);
        chk("eq_no_rst", rmax, 0);
        chk("eq_sel", brg_sel, 1);

        // reset during SWITCH
        req_a = 1'b1;
        sel_a = 2'b10;
        wait_rst_hi(600);
        chk("mr_in_switch", brg_reset, 1);
        cyc();
        cyc();
        #2 reset = 1'b1;
        g0 = g_a + g_b;
        #1;
        chk("mr_brg_reset", brg_reset, 1);
        chk("mr_brg_sel", brg_sel, 0);
        chk("mr_busy", busy, 1);
        chk("mr_gnt", {gnt_a, gnt_b}, 0);
        chk("mr_tmo", tmo_err, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk($sformatf("mr_init_c%0d", i), brg_reset, (i <= 3));
        end
        wait_gnt(1500);
        chk("mr_regnt_a", gnt_a, 1);
        chk("mr_regnt_sel", brg_sel, 2);
        req_a = 1'b0;
        cyc();
        chk("mr_gnt_count", g_a + g_b - g0, 1);
        chk("no_overlap", ovl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/brg_rate_ctrl.md
Name: brg_rate_ctrl

Overview:
- Controller that owns the baud-rate generator's select and reset inputs.
- Two requesters compete for rate changes: A is the host config register, B is the autobaud logic. The block arbitrates between them round-robin.
- Each rate switch is glitch-free: the block waits for the generator output's low phase, pulses the generator's reset while sel changes, then confirms the new clock is running before granting.
- Sits between the UART config/autobaud logic and the baud-rate generator. 125 MHz system clock.

Parameters:
- RST_CYC, 4, cycles brg_reset is held high per switch (also used after reset release).
- TMO_CYC, 1024, cycles to wait for a generator edge before forcing progress. Must exceed the slowest half-period, which is 408 cycles at sel=11.
- SYNC_STAGES, 2, flop stages synchronising brg_clkout into clk.

Ports:
- clk  in  1  system clock, 125 MHz.
- reset  in  1  asynchronous, active-high reset.
- req_a  in  1  requester A rate-change request, held high until gnt_a.
- sel_a  in  2  requester A target rate: 00=115200, 01=38400, 10=19200, 11=9600. Stable while req_a is high.
- req_b  in  1  requester B request, same rules as A.
- sel_b  in  2  requester B target rate.
- gnt_a  out  1  one-cycle pulse: A's rate is now active.
- gnt_b  out  1  one-cycle pulse: B's rate is now active.
- brg_clkout  in  1  generator output, synchronised internally.
- brg_sel  out  2  generator select, registered.
- brg_reset  out  1  generator reset, registered, active-high.
- busy  out  1  high whenever state is not IDLE.
- tmo_err  out  1  sticky flag: a timeout occurred. Cleared by reset only.

Behaviour:
- Reset values (asynchronous):
  - state=INIT, brg_sel=00, brg_reset=1, busy=1.
  - gnt_a=0, gnt_b=0, tmo_err=0.
  - rr_ptr=A, sync chain=0, counters=0.
- Edge detection: after the SYNC_STAGES synchroniser, a registered previous value gives rise/fall pulses.
- FSM states:
  - INIT: brg_reset=1 for RST_CYC cycles, then go to IDLE with brg_reset=0.
  - IDLE: pick a winner.
    - Only one request high: that requester wins.
    - Both high: the requester not equal to rr_ptr wins.
    - Latch the winner id and its sel into tgt.
    - If tgt == brg_sel (fast path): next cycle go to GRANT, with no reset pulse.
    - Otherwise go to WAIT_LOW.
  - WAIT_LOW: wait for a synchronised falling edge, then go to SWITCH.
    - If the wait counter reaches TMO_CYC-1: set tmo_err and go to SWITCH anyway.
  - SWITCH: brg_reset=1 and brg_sel=tgt on the same cycle; hold for RST_CYC cycles, then go to SETTLE with brg_reset=0.
  - SETTLE: wait for the first synchronised rising edge, then go to GRANT.
    - Timeout behaves as in WAIT_LOW: set tmo_err and proceed.
  - GRANT: pulse gnt_<winner> for one cycle, set rr_ptr=winner, go to IDLE.
- Each wait state clears its counter on entry. The counter is 11 bits and saturates; it never wraps.
- Winner latching:
  - A request dropped after latching is ignored; the switch completes and gnt still pulses.
  - sel changes after latching are ignored.
- A requester that keeps req high after its gnt is re-arbitrated from IDLE, one cycle after GRANT.
- Both requests high in IDLE with equal sel: the winner is granted via the fast path, and the loser is served next, also via the fast path.
- gnt_a and gnt_b are never high together.
- brg_sel changes only on SWITCH entry.
- Reset asserted mid-switch: immediate return to reset values. No gnt is issued and pending requests must be re-arbitrated.
- Fast-path latency: req sampled in IDLE at cycle N gives gnt at cycle N+2.

Decomposition:
- Shared package brg_pkg:
  - rate codes RATE_115200=2'b00 … RATE_9600=2'b11;
  - state enum {INIT, IDLE, WAIT_LOW, SWITCH, SETTLE, GRANT};
  - DIV1=34 and per-rate half-period cycle counts (34, 102, 204, 408), used by the bench and the TMO_CYC check.
- One sub-module, brg_edge_sync: an N-stage synchroniser plus rise/fall pulse outputs.

Test Plan:
- Reset release, no requests → brg_reset high for 4 cycles after reset falls, then 0; brg_sel=00; busy falls at cycle 5; gnt never pulses.
- req_a with sel_a=11 (generator model running) → brg_reset pulses for 4 cycles after a clkout fall; brg_sel=11 during that pulse; gnt_a arrives after the next clkout rise; busy drops the cycle after gnt_a.
- req_a and req_b raised in the same cycle with sel 01 and 10, rr_ptr=A → B granted first (brg_sel=10), then A (brg_sel=01); exactly 2 single-cycle gnts, never overlapping.
- req_b with sel_b=00 while brg_sel=00 → gnt_b 2 cycles after req sampled; brg_reset stays 0.
- brg_clkout stuck at 0 and req_a sel_a=01 → tmo_err=1 after 1024 cycles in WAIT_LOW and again in SETTLE. gnt_a is still issued; tmo_err persists until reset.
- reset asserted during SWITCH → outputs return to reset values asynchronously with no gnt; after release, INIT repeats and a held req_a is re-serviced.
